// File: rtl/bus_pkg.sv
// Shared definitions for the bus_if slave memory.
// Contents:
//   bus_slv_state_e  responder FSM state encoding
//   RW_WRITE/RW_READ rw signal encoding
//   BUS_ADDR_W/BUS_DATA_W default bus widths
//   BUS_CNT_W        wait-state counter width (holds 0..15 plus headroom)
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_slv_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_CNT_W  = $clog2(16) + 1;

endpackage

// File: rtl/bus_slave_regfile.sv
// DEPTH x DATA_W word storage for bus_slave_mem.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every word)
//   we_i        write enable, commits wdata_i to word waddr_i on the rising edge
//   waddr_i     write word index
//   wdata_i     write data
//   raddr_i     read word index
//   rdata_o     combinational read data of word raddr_i
module bus_slave_regfile #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so every index value names a real word.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_slave_mem.sv
// Slave end of the bus_if valid/ready protocol: word-addressed memory with
// programmable wait states and a one-cycle ready acknowledge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   addr        byte address from master (addr[1:0] ignored)
//   wdata       write data from master
//   rw          1 = write, 0 = read
//   valid       master request valid
//   ready       transfer acknowledge, one-cycle pulse
//   rdata       read data, valid while ready = 1, held until the next read
//   err         out-of-range flag, valid while ready = 1
//   busy        high whenever the FSM is not idle
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned        ADDR_W      = BUS_ADDR_W,
  parameter int unsigned        DATA_W      = BUS_DATA_W,
  parameter int unsigned        DEPTH       = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = ADDR_W'(32'h0000_1000),
  parameter int unsigned        WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rw,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = BUS_CNT_W;

  bus_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Latched request
  logic              in_range_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;

  // Registered outputs
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] off_s;
  logic              dec_in_range_s;
  logic [IDX_W-1:0]  dec_idx_s;
  logic              capture_s;
  logic              cur_in_range_s;
  logic [IDX_W-1:0]  cur_idx_s;
  logic              cur_rw_s;
  logic              enter_ack_s;
  logic              we_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              unused_off_s;

  // Address decode of the live bus address.
  assign off_s          = addr - BASE_ADDR;
  assign dec_in_range_s = (addr >= BASE_ADDR) &&
                          (off_s[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH));
  assign dec_idx_s      = off_s[2 +: IDX_W];
  assign unused_off_s   = ^off_s[1:0];

  // Next-state logic and wait-state counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          capture_s = 1'b1;
          cnt_d     = CNT_W'(WAIT_CYCLES);
          state_d   = (WAIT_CYCLES == 32'd0) ? ST_ACK : ST_WAIT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // With zero wait states ACK is entered on the capture edge itself, so the
  // request must be taken from the bus rather than from the latch.
  assign cur_in_range_s = capture_s ? dec_in_range_s : in_range_q;
  assign cur_idx_s      = capture_s ? dec_idx_s      : idx_q;
  assign cur_rw_s       = capture_s ? rw             : rw_q;

  assign enter_ack_s = (state_d == ST_ACK) && (state_q != ST_ACK);

  // Commit only on a completed handshake; an abandoned ACK writes nothing.
  assign we_s = (state_q == ST_ACK) && valid && (rw_q == RW_WRITE) && in_range_q;

  // Output next-values, all taken from the next state.
  always_comb begin
    ready_d = (state_d == ST_ACK);
    busy_d  = (state_d != ST_IDLE);
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (enter_ack_s) begin
      err_d = !cur_in_range_s;
      if (cur_rw_s == RW_READ) begin
        rdata_d = cur_in_range_s ? mem_rdata_s : '0;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Request latch, loaded once per transfer in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_range_q <= 1'b0;
      idx_q      <= '0;
      rw_q       <= RW_READ;
      wdata_q    <= '0;
    end else if (capture_s) begin
      in_range_q <= dec_in_range_s;
      idx_q      <= dec_idx_s;
      rw_q       <= rw;
      wdata_q    <= wdata;
    end
  end

  bus_slave_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_s),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (cur_idx_s),
    .rdata_o (mem_rdata_s)
  );

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: three instances with 1, 0 and 3
// wait states, a reference memory model and an expected-response queue.
module tb_bus_slave_mem;

  localparam int NDUT = 3;

  function automatic int wc_of(input int g);
    if (g == 0) return 1;
    else if (g == 1) return 0;
    else return 3;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_s  [NDUT];
  logic [31:0] wdata_s [NDUT];
  logic [31:0] rdata_w [NDUT];
  logic        rw_s    [NDUT];
  logic        valid_s [NDUT];
  logic        ready_w [NDUT];
  logic        err_w   [NDUT];
  logic        busy_w  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bus_slave_mem #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH       (16),
      .BASE_ADDR   (32'h0000_1000),
      .WAIT_CYCLES (wc_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr_s[g]),
      .wdata (wdata_s[g]),
      .rw    (rw_s[g]),
      .valid (valid_s[g]),
      .ready (ready_w[g]),
      .rdata (rdata_w[g]),
      .err   (err_w[g]),
      .busy  (busy_w[g])
    );
  end

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m   [NDUT][16];
  logic [31:0] last_rd [NDUT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      last_rd[d] = 32'h0;
      for (int i = 0; i < 16; i++) mem_m[d][i] = 32'h0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge
  // with valid still high so the next call can follow back-to-back.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input bit abandon);
    exp_t e;
    bit   inr;
    int   idx;
    int   lat;
    bit   seen;
    inr   = (a >= 32'h1000) && (((a - 32'h1000) >> 2) < 32'd16);
    idx   = int'(((a - 32'h1000) >> 2) & 32'hF);
    e.d   = d;
    e.err = !inr;
    e.lat = wc_of(d) + 1;
    if (w) begin
      e.rdata = last_rd[d];
    end else begin
      e.rdata    = inr ? mem_m[d][idx] : 32'h0;
      last_rd[d] = e.rdata;
    end
    sb.push_back(e);
    addr_s[d]  = a;
    wdata_s[d] = wd;
    rw_s[d]    = w;
    valid_s[d] = 1'b1;
    @(posedge clk);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_w[d]) begin
        seen = 1'b1;
        break;
      end
      lat++;
      @(posedge clk);
    end
    e = sb.pop_front();
    if (!seen) begin
      chk("ready_timeout", 32'd0, 32'd1);
      valid_s[d] = 1'b0;
      return;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rdata", rdata_w[d], e.rdata);
    chk("err", 32'(err_w[d]), 32'(e.err));
    chk("busy_in_ack", 32'(busy_w[d]), 32'd1);
    if (abandon) valid_s[d] = 1'b0;
    else if (w && inr) mem_m[d][idx] = wd;
    @(posedge clk);
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready_w[d]), 32'd0);
    chk("busy_after", 32'(busy_w[d]), 32'd0);
    chk("err_cleared", 32'(err_w[d]), 32'd0);
    chk("rdata_hold", rdata_w[d], e.rdata);
  endtask

  task automatic idle(input int d, input int n);
    valid_s[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    bit pulse;
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      addr_s[d] = 32'h0; wdata_s[d] = 32'h0; rw_s[d] = 1'b0; valid_s[d] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_ready", 32'(ready_w[d]), 32'd0);
      chk("rst_rdata", rdata_w[d], 32'd0);
      chk("rst_err", 32'(err_w[d]), 32'd0);
      chk("rst_busy", 32'(busy_w[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Read after reset, then write/read with one wait state.
    xfer(0, 32'h1000, 32'h0, 1'b0, 1'b0);
    idle(0, 1);
    xfer(0, 32'h1000, 32'h0000_ABCD, 1'b1, 1'b0);
    idle(0, 2);
    xfer(0, 32'h1000, 32'h0, 1'b0, 1'b0);

    // Back-to-back write then read of the same word.
    xfer(0, 32'h1004, 32'h0000_1234, 1'b1, 1'b0);
    xfer(0, 32'h1004, 32'h0, 1'b0, 1'b0);
    idle(0, 1);

    // Last in-range word, with ignored byte-offset bits.
    xfer(0, 32'h103F, 32'hCAFE_F00D, 1'b1, 1'b0);
    xfer(0, 32'h103C, 32'h0, 1'b0, 1'b0);

    // Out-of-range just below base and just past the top.
    xfer(0, 32'h0FFC, 32'h0000_DEAD, 1'b1, 1'b0);
    xfer(0, 32'h1040, 32'h0, 1'b0, 1'b0);
    idle(0, 1);

    // Abandoned write must not commit.
    xfer(0, 32'h1008, 32'h0000_0099, 1'b1, 1'b1);
    idle(0, 1);
    xfer(0, 32'h1008, 32'h0, 1'b0, 1'b0);

    // Full sweep: every word matches the model.
    for (int i = 0; i < 16; i++) xfer(0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0, 1'b0);
    idle(0, 1);

    // Zero and three wait-state instances.
    xfer(1, 32'h1010, 32'h0000_1111, 1'b1, 1'b0);
    xfer(1, 32'h1010, 32'h0, 1'b0, 1'b0);
    idle(1, 1);
    xfer(2, 32'h1014, 32'h0000_3333, 1'b1, 1'b0);
    xfer(2, 32'h1014, 32'h0, 1'b0, 1'b0);
    idle(2, 1);

    // Reset in the middle of a waiting write.
    addr_s[2] = 32'h1008; wdata_s[2] = 32'h0000_0055; rw_s[2] = 1'b1; valid_s[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", 32'(busy_w[2]), 32'd1);
    chk("wait_ready", 32'(ready_w[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_w[2]), 32'd0);
    chk("midrst_ready", 32'(ready_w[2]), 32'd0);
    valid_s[2] = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulse = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_w[2]) pulse = 1'b1;
    end
    chk("no_ready_after_rst", 32'(pulse), 32'd0);
    xfer(2, 32'h1008, 32'h0, 1'b0, 1'b0);
    idle(2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
